// File: rtl/interface_demux.sv
// Egress demux: pops frames from the shared frame buffer into up to four per-MAC tx FIFO pairs.
// Define INTERFACE_DEMUX_MCAST_EN to write a frame to every destination port at once.
module interface_demux #(
    parameter logic [10:0] LEN_MAX = 11'd1518
) (
    input  logic        clk_sys,
    input  logic        rstn_sys,
    output logic        sfifo_rd,
    input  logic [7:0]  sfifo_dout,
    output logic        ptr_sfifo_rd,
    input  logic [19:0] ptr_sfifo_dout,
    input  logic        ptr_sfifo_empty,
    output logic [3:0]  tx_data_fifo_wr,
    output logic [7:0]  tx_data_fifo_din,
    input  logic [3:0]  tx_data_fifo_afull,
    output logic [3:0]  tx_ptr_fifo_wr,
    output logic [15:0] tx_ptr_fifo_din,
    input  logic [3:0]  tx_ptr_fifo_full,
    output logic [15:0] drop_cnt
);

    typedef enum logic [2:0] {
        StIdle, StPtrRd, StPtrWait, StArb, StXfer, StDrop, StPtrWr
    } state_t;

    state_t      r_state, w_state_d;
    logic [3:0]  r_dst, r_src;
    logic [10:0] r_len, r_cnt;
    logic        r_wr_en;
    logic [15:0] r_drop_cnt;

    logic [3:0]  w_masked, w_eff;
    logic        w_bad, w_busy, w_rd_more;
    logic        w_unused;

    assign w_unused = ptr_sfifo_dout[11];

    // Never reflect a frame back to the port it came from.
    assign w_masked = r_dst & ~r_src;
`ifdef INTERFACE_DEMUX_MCAST_EN
    assign w_eff = w_masked;
`else
    assign w_eff = w_masked & (~w_masked + 4'd1);
`endif

    assign w_bad     = (w_eff == 4'd0) || (r_len == 11'd0) || (r_len > LEN_MAX);
    assign w_busy    = |((tx_data_fifo_afull | tx_ptr_fifo_full) & w_eff);
    assign w_rd_more = (r_cnt != r_len);

    always_comb begin
        w_state_d      = r_state;
        sfifo_rd       = 1'b0;
        ptr_sfifo_rd   = 1'b0;
        tx_ptr_fifo_wr = 4'd0;
        unique case (r_state)
            StIdle:    if (!ptr_sfifo_empty) w_state_d = StPtrRd;
            StPtrRd: begin
                ptr_sfifo_rd = 1'b1;
                w_state_d    = StPtrWait;
            end
            StPtrWait: w_state_d = StArb;
            StArb: begin
                if (w_bad)        w_state_d = StDrop;
                else if (!w_busy) w_state_d = StXfer;
            end
            // Stay one cycle past the last read so the final byte is written.
            StXfer: begin
                if (w_rd_more) sfifo_rd = 1'b1;
                else           w_state_d = StPtrWr;
            end
            StDrop: begin
                if (w_rd_more) sfifo_rd = 1'b1;
                else           w_state_d = StIdle;
            end
            StPtrWr: begin
                tx_ptr_fifo_wr = w_eff;
                w_state_d      = StIdle;
            end
            default:   w_state_d = StIdle;
        endcase
    end

    assign tx_data_fifo_wr  = r_wr_en ? w_eff : 4'd0;
    assign tx_data_fifo_din = r_wr_en ? sfifo_dout : 8'd0;
    assign tx_ptr_fifo_din  = (r_state == StPtrWr) ? {r_src, 1'b0, r_len} : 16'd0;
    assign drop_cnt         = r_drop_cnt;

    always_ff @(posedge clk_sys or negedge rstn_sys) begin
        if (!rstn_sys) begin
            r_state    <= StIdle;
            r_dst      <= 4'd0;
            r_src      <= 4'd0;
            r_len      <= 11'd0;
            r_cnt      <= 11'd0;
            r_wr_en    <= 1'b0;
            r_drop_cnt <= 16'd0;
        end else begin
            r_state <= w_state_d;
            if (r_state == StPtrWait) begin
                r_dst <= ptr_sfifo_dout[19:16];
                r_src <= ptr_sfifo_dout[15:12];
                r_len <= ptr_sfifo_dout[10:0];
            end
            if (r_state == StArb) r_cnt <= 11'd0;
            else if (sfifo_rd)    r_cnt <= r_cnt + 11'd1;
            r_wr_en <= (r_state == StXfer) && sfifo_rd;
            if ((r_state == StDrop) && !w_rd_more && (r_drop_cnt != 16'hFFFF)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/interface_demux.md
# interface_demux

Egress-side counterpart of the switch core's ingress multiplexer. It pops frame descriptors and payload bytes from the shared backend frame buffer (data FIFO + 20-bit pointer FIFO) and distributes each frame to one or more of four per-MAC transmit FIFO pairs (data + pointer). Each frame is admitted only when every destination port has room for a maximum-size frame. Frames that are malformed or have no destination are drained and counted as drops.

## Interface
- `LEN_MAX`, 11'd1518: largest accepted frame length in bytes; longer frames are dropped.
- `clk_sys`  in  1  system clock.
- `rstn_sys`  in  1  reset, asynchronous, active-low.
- `sfifo_rd`  out  1  pop strobe for the shared data FIFO (standard FIFO: `sfifo_dout` is valid 1 cycle after `sfifo_rd`).
- `sfifo_dout`  in  8  shared data FIFO byte.
- `ptr_sfifo_rd`  out  1  pop strobe for the shared pointer FIFO (standard FIFO, 1-cycle read latency).
- `ptr_sfifo_dout`  in  20  descriptor: [19:16] destination mask, [15:12] source port one-hot, [11] reserved, [10:0] length in bytes.
- `ptr_sfifo_empty`  in  1  pointer FIFO empty.
- `tx_data_fifo_wr`  out  4  per-port data write strobes.
- `tx_data_fifo_din`  out  8  data byte, broadcast to all ports.
- `tx_data_fifo_afull`  in  4  per-port flag: fewer than 2048 free bytes.
- `tx_ptr_fifo_wr`  out  4  per-port descriptor write strobes.
- `tx_ptr_fifo_din`  out  16  {source one-hot[3:0], 1'b0, length[10:0]}, broadcast.
- `tx_ptr_fifo_full`  in  4  per-port pointer FIFO full.
- `drop_cnt`  out  16  saturating count of dropped frames.

## Operation
- States: IDLE, PTR_RD, PTR_WAIT, ARB, XFER, DROP, PTR_WR.
- **IDLE:** if `!ptr_sfifo_empty`, go to PTR_RD.
- **PTR_RD:** `ptr_sfifo_rd`=1 for exactly this one cycle, then go to PTR_WAIT.
- **PTR_WAIT:** latch `ptr_sfifo_dout` into dst, src and len, then go to ARB.
- **ARB:** compute eff = dst & ~src (no reflection to the source port), then apply the multicast rule (see Configuration).
  - If eff==0, or len==0, or len>`LEN_MAX`: go to DROP.
  - Otherwise stay in ARB until ((`tx_data_fifo_afull` | `tx_ptr_fifo_full`) & eff)==0, then go to XFER.
  - The admission check is made only here. Flags changing during XFER are ignored; afull guarantees room.
- **XFER:**
  - `sfifo_rd`=1 for exactly len consecutive cycles, driven by an 11-bit byte counter.
  - Each read is followed one cycle later by `tx_data_fifo_wr`=eff and `tx_data_fifo_din`=`sfifo_dout`.
  - Go to PTR_WR after the last data write.
- **PTR_WR:** `tx_ptr_fifo_wr`=eff for one cycle with `tx_ptr_fifo_din`={src, 1'b0, len}, then go to IDLE.
- **DROP:**
  - If len>0, `sfifo_rd`=1 for len cycles with no tx writes.
  - `drop_cnt` increments once, saturating at 16'hFFFF.
  - Then go to IDLE.
  - len==0 consumes the descriptor only.
- Frames are strictly serialized: no overlap of descriptor fetch with the previous frame's data.

## Timing
- Reset values: all strobes 0, `tx_data_fifo_din`=0, `tx_ptr_fifo_din`=0, `drop_cnt`=0, state IDLE.
- T0 is the first IDLE cycle with `ptr_sfifo_empty`=0, with all eff ports free. Then:
  - `ptr_sfifo_rd` at T0+1.
  - `sfifo_rd` at T0+4 … T0+3+len.
  - `tx_data_fifo_wr` at T0+5 … T0+4+len.
  - `tx_ptr_fifo_wr` at T0+5+len.
  - IDLE at T0+6+len; the next `ptr_sfifo_rd` no earlier than T0+7+len.
- A stall in ARB delays the whole sequence by the stall length. There are no bubbles inside XFER.
- An asynchronous reset mid-frame clears all state immediately. Partially written tx FIFO contents are not repaired: the system resets all FIFOs with the same reset.
- len counter and comparisons are 11-bit unsigned.

## Configuration
- `INTERFACE_DEMUX_MCAST_EN` defined: eff keeps all set bits, and one frame is written to every port in eff simultaneously.
- Undefined: eff is reduced to its lowest set bit (port 0 highest priority). Other destinations are silently discarded and do not count as drops.

## Test plan
- Descriptor {4'b0010, 4'b0001, 0, 11'd64}, all ports free:
  - 64 bytes 0x00..0x3F appear on port 1 only.
  - `tx_ptr_fifo_din`=16'h1040 at T0+69.
  - `sfifo_rd` count=64.
- Descriptor dst=4'b0011, src=4'b0001:
  - Port 0 is excluded; writes go to port 1 only.
  - Dst=4'b0001 with the same src gives a drop: 64 `sfifo_rd`, no writes, `drop_cnt`=1.
- `tx_data_fifo_afull[2]`=1 for 20 cycles, frame dst=4'b0100:
  - Block holds in ARB with no `sfifo_rd`.
  - Transfer starts 1 cycle after deassertion.
  - Flag reasserted mid-XFER does not stall.
- Length 0 and length 1519 descriptors:
  - Both dropped; `drop_cnt`=2.
  - 0 and 1519 data pops respectively; the next valid frame is transferred intact.
- With MCAST_EN, dst=4'b1110, src=4'b0001:
  - Identical bytes to ports 1, 2, 3 with `tx_data_fifo_wr`=4'b1110.
  - Without the macro, port 1 only.
- Reset asserted at byte 30 of a 100-byte frame:
  - All outputs 0 immediately; state IDLE after release.
  - `drop_cnt`=0.
